// File: rtl/lock_pkg.sv
// Shared encodings for the password-lock session controller: FSM states and keypad codes.
package lock_pkg;

    typedef enum logic [2:0] {
        NOPWD       = 3'd0,
        LOCKED      = 3'd1,
        SET_ENTRY   = 3'd2,
        CHECK_ENTRY = 3'd3,
        UNLOCKED    = 3'd4,
        ALARM       = 3'd5
    } state_e;

    localparam logic [3:0] KEY_CLEAR     = 4'hA;
    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

    function automatic logic is_entry_state(input state_e s);
        return (s == SET_ENTRY) || (s == CHECK_ENTRY);
    endfunction

endpackage

// File: rtl/entry_buffer.sv
// BCD digit-entry shift register with a digit counter; new digits enter the low nibble.
module entry_buffer #(
    parameter int DIGITS = 3,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  shift_en,
    input  logic [3:0]            digit,
    output logic [4*DIGITS-1:0]   entry,
    output logic [CW-1:0]         entry_cnt,
    output logic                  full
);

    logic [4*DIGITS-1:0] entry_q, entry_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS+3:0] shifted;

    assign full    = (cnt_q == CW'(DIGITS));
    assign shifted = {entry_q, digit};

    always_comb begin
        entry_d = entry_q;
        cnt_d   = cnt_q;
        if (clr) begin
            entry_d = '0;
            cnt_d   = '0;
        end else if (shift_en && !full) begin
            entry_d = shifted[4*DIGITS-1:0];
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
            cnt_q   <= '0;
        end else begin
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign entry     = entry_q;
    assign entry_cnt = cnt_q;

endmodule

// File: rtl/lock_session_ctrl.sv
// Password-lock session sequencer: entry/check/set flow, wrong-attempt alarm and idle timeout.
module lock_session_ctrl
    import lock_pkg::*;
#(
    parameter int DIGITS      = 3,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           set_btn,
    input  logic                           check_btn,
    input  logic                           confirm_btn,
    input  logic                           key_valid,
    input  logic [3:0]                     key_num,
    output logic [2:0]                     mode,
    output logic [4*DIGITS-1:0]            entry,
    output logic [$clog2(DIGITS+1)-1:0]    entry_cnt,
    output logic                           pwd_set,
    output logic                           set_led,
    output logic                           unlocked,
    output logic [$clog2(MAX_TRIES+1)-1:0] wrong_cnt,
    output logic                           alarm
);

    localparam int CW  = $clog2(DIGITS + 1);
    localparam int WCW = $clog2(MAX_TRIES + 1);
    localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] stored_q, stored_d;
    logic                pwd_set_q, pwd_set_d;
    logic [WCW-1:0]      wrong_q, wrong_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic                buf_clr, buf_shift, buf_full, key_acc, timed;
    logic [4*DIGITS-1:0] entry_w;
    logic [CW-1:0]       cnt_w;

    entry_buffer #(.DIGITS(DIGITS), .CW(CW)) u_entry_buffer (
        .clk       (clk),
        .rst       (rst),
        .clr       (buf_clr),
        .shift_en  (buf_shift),
        .digit     (key_num),
        .entry     (entry_w),
        .entry_cnt (cnt_w),
        .full      (buf_full)
    );

    assign timed = is_entry_state(state_q) || (state_q == UNLOCKED);

    always_comb begin
        state_d   = state_q;
        stored_d  = stored_q;
        pwd_set_d = pwd_set_q;
        wrong_d   = wrong_q;
        timer_d   = timer_q;
        buf_clr   = 1'b0;
        buf_shift = 1'b0;
        key_acc   = 1'b0;

        case (state_q)
            NOPWD: begin
                if (set_btn) state_d = SET_ENTRY;
            end
            LOCKED: begin
                if (set_btn)        state_d = SET_ENTRY;
                else if (check_btn) state_d = CHECK_ENTRY;
            end
            SET_ENTRY, CHECK_ENTRY: begin
                // confirm has priority; a key arriving with it is dropped
                if (confirm_btn) begin
                    if (buf_full) begin
                        buf_clr = 1'b1;
                        if (state_q == SET_ENTRY) begin
                            stored_d  = entry_w;
                            pwd_set_d = 1'b1;
                            wrong_d   = '0;
                            state_d   = LOCKED;
                        end else if (entry_w == stored_q) begin
                            wrong_d = '0;
                            state_d = UNLOCKED;
                        end else begin
                            wrong_d = wrong_q + WCW'(1);
                            state_d = (wrong_d == WCW'(MAX_TRIES)) ? ALARM : LOCKED;
                        end
                    end
                end else if (key_valid) begin
                    if (key_num == KEY_CLEAR) begin
                        buf_clr = 1'b1;
                        key_acc = 1'b1;
                    end else if (key_num <= KEY_MAX_DIGIT && !buf_full) begin
                        buf_shift = 1'b1;
                        key_acc   = 1'b1;
                    end
                end
            end
            UNLOCKED: begin
                if (set_btn)        state_d = SET_ENTRY;
                else if (check_btn) state_d = LOCKED;
            end
            default: ;
        endcase

        // any activity restarts the idle timer, so expiry only applies when nothing else happened
        if (state_d != state_q || key_acc) begin
            timer_d = '0;
        end else if (timed) begin
            if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                timer_d = '0;
                buf_clr = 1'b1;
                state_d = (state_q == SET_ENTRY && !pwd_set_q) ? NOPWD : LOCKED;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= NOPWD;
            stored_q  <= '0;
            pwd_set_q <= 1'b0;
            wrong_q   <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            stored_q  <= stored_d;
            pwd_set_q <= pwd_set_d;
            wrong_q   <= wrong_d;
            timer_q   <= timer_d;
        end
    end

    assign mode      = state_q;
    assign entry     = entry_w;
    assign entry_cnt = cnt_w;
    assign pwd_set   = pwd_set_q;
    assign set_led   = (state_q == SET_ENTRY);
    assign unlocked  = (state_q == UNLOCKED);
    assign alarm     = (state_q == ALARM);
    assign wrong_cnt = wrong_q;

endmodule

// File: doc/lock_session_ctrl.md
Name: lock_session_ctrl

Overview:
- Central sequencer for the password lock. It consumes scan-keypad digit events and the set/check/confirm button pulses.
- Owns the digit-entry buffer, the stored password, the wrong-attempt counter, the inactivity timeout and the alarm lockout.
- Drives the 7-segment display controller (entry buffer, digit count, mode) and the status LEDs.
- Sits between the keyboard scanner and the display/LED logic in the lock top level.

Parameters:
- DIGITS, 3: password length in decimal digits; the buffer is 4*DIGITS bits.
- MAX_TRIES, 3: consecutive wrong attempts that trigger the alarm.
- TIMEOUT_CYC, 500_000_000: idle cycles (5 s at 100 MHz) before an entry is aborted or the lock re-locks.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- set_btn  in  1  one-cycle pulse, already debounced and edge-detected
- check_btn  in  1  one-cycle pulse
- confirm_btn  in  1  one-cycle pulse
- key_valid  in  1  one-cycle pulse, key_num valid
- key_num  in  4  key code: 0-9 digit, 0xA clear, others ignored
- mode  out  3  current state encoding (package constant)
- entry  out  4*DIGITS  BCD entry buffer; newest digit in the low nibble
- entry_cnt  out  $clog2(DIGITS+1)  digits entered
- pwd_set  out  1  a password is stored
- set_led  out  1  high in SET_ENTRY
- unlocked  out  1  high in UNLOCKED
- wrong_cnt  out  $clog2(MAX_TRIES+1)  consecutive failures
- alarm  out  1  high in ALARM

Behaviour:
- Reset (async, also mid-operation):
  - state=NOPWD; entry, entry_cnt, stored password, wrong_cnt, timer = 0.
  - pwd_set, set_led, unlocked, alarm = 0.
- All outputs are registered or decoded from registered state. Response is one clock after the input pulse.
- States and transitions:
  - NOPWD: set_btn -> SET_ENTRY. Other inputs are ignored.
  - LOCKED: set_btn -> SET_ENTRY; check_btn -> CHECK_ENTRY.
  - SET_ENTRY / CHECK_ENTRY (entry states):
    - Digit with entry_cnt<DIGITS: entry <= {entry[4*DIGITS-5:0], key_num}, entry_cnt+1.
    - Digit with buffer full: ignored.
    - 0xA: entry=0, entry_cnt=0.
    - Codes 0xB-0xF: ignored.
    - confirm_btn with entry_cnt<DIGITS: ignored, state unchanged.
  - SET_ENTRY, confirm with buffer full: stored <= entry; pwd_set=1; wrong_cnt=0; entry cleared -> LOCKED.
  - CHECK_ENTRY, confirm with buffer full:
    - Match: wrong_cnt=0 -> UNLOCKED.
    - Mismatch: wrong_cnt+1. If the new value equals MAX_TRIES -> ALARM, else -> LOCKED.
    - Entry is cleared in both cases.
  - UNLOCKED: set_btn -> SET_ENTRY (change password); check_btn -> LOCKED (manual relock).
  - ALARM: absorbing. All inputs are ignored until rst. wrong_cnt holds MAX_TRIES.
- Timeout:
  - Timer is cleared on any accepted key_valid, on any state change, and on any button pulse that causes a transition.
  - In entry states and UNLOCKED, the timer increments every cycle.
  - On reaching TIMEOUT_CYC-1:
    - SET_ENTRY -> LOCKED if pwd_set, else NOPWD.
    - CHECK_ENTRY -> LOCKED.
    - UNLOCKED -> LOCKED.
    - Entry is cleared. No wrong attempt is counted. The stored password is unchanged.
  - The timer is held at 0 in NOPWD, LOCKED and ALARM.
- Simultaneous events:
  - confirm_btn with key_valid in the same cycle: confirm wins and the key is dropped.
  - set_btn with check_btn in LOCKED: set wins.
  - Timeout expiry in the same cycle as an accepted key or confirm: the key or confirm wins and the timer restarts.
- Stored password is retained in every state except reset.
- Digit entry during SET_ENTRY does not disturb the stored password until confirm.

Decomposition:
- Package lock_pkg:
  - State encodings: NOPWD, LOCKED, SET_ENTRY, CHECK_ENTRY, UNLOCKED, ALARM.
  - Key code constants: KEY_CLEAR=4'hA, KEY_MAX_DIGIT=4'd9.
- Sub-module entry_buffer: shift register, digit counter and clear/full logic, with load/clear controls from the FSM.
- Timer and comparator stay inline.

Test Plan:
- Reset, set_btn, keys 1,2,3, confirm -> LOCKED, pwd_set=1, entry=0. Then check_btn, keys 1,2,3, confirm -> UNLOCKED, wrong_cnt=0.
- Three checks with 4,5,6 against stored 123 -> wrong_cnt 1, 2, then ALARM with alarm=1. Further set/check/keys are ignored until rst; rst returns to NOPWD with pwd_set=0.
- In CHECK_ENTRY, keys 7,8, confirm -> ignored. Key 0xA -> entry_cnt=0. Keys 9,9,9,9 -> entry=0x999, fourth digit dropped.
- With TIMEOUT_CYC=16 and keys 1,2 in CHECK_ENTRY, then idle 16 cycles -> LOCKED, entry=0, wrong_cnt unchanged. Same idle in UNLOCKED -> LOCKED.
- confirm_btn and key_valid asserted in the same cycle with the buffer full -> confirm processed, key ignored. Async rst asserted mid-entry -> all outputs 0 immediately, before the next clock edge.
- In UNLOCKED, set_btn, keys 4,5,6, confirm -> new password 456. The old password 123 then fails a check; 456 unlocks.
